sfifo_axis: RTL and testbench

Parametrised synchronous FIFO with AXI-Stream slave/master handshakes, tlast passthrough, arbitrary (non-power-of-2) depth, occupancy level, almost-full/almost-empty flags, synchronous flush and an optional output register stage. It is the general-purpose buffering element between AXI-Stream producer/consumer blocks in the design. It replaces raw rd_en/wr_en FIFO use wherever backpressure must be honoured without data loss.

---
 rtl/sfifo_axis.sv | 132 +++++++++++++
 tb/tb_sfifo_axis.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_axis.sv
// rtl/sfifo_axis.sv - AXI-Stream synchronous FIFO, any depth, optional output register
module sfifo_axis #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int CAP       = DEPTH + OUT_REG,
  localparam int LW        = $clog2(CAP + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + 1);

  // tlast is kept in the top bit so it can never drift away from its word
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [SW-1:0]       st_cnt;
  logic                push;
  logic                st_pop;
  logic                out_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Full storage blocks the writer even if a word leaves this cycle
  assign s_axis_tready = reset && !flush && (st_cnt != SW'(DEPTH));
  assign push          = s_axis_tvalid && s_axis_tready;

  assign almost_full  = (32'(level) >= AF_THRESH);
  assign almost_empty = (32'(level) <= AE_THRESH);

  // Storage array write; contents are never cleared, only pointers are
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Pointer, storage count and total occupancy bookkeeping; flush wins over traffic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      st_cnt <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      st_cnt <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (st_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !st_pop) begin
        st_cnt <= st_cnt + SW'(1);
      end else if (!push && st_pop) begin
        st_cnt <= st_cnt - SW'(1);
      end
      if (push && !out_pop) begin
        level <= level + LW'(1);
      end else if (!push && out_pop) begin
        level <= level - LW'(1);
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_fwft
      logic [DATA_WIDTH:0] head;

      assign head          = mem[rd_ptr];
      assign m_axis_tvalid = (level != '0);
      // Data is forced to zero while empty so reset shows a clean bus
      assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
      assign m_axis_tlast  = m_axis_tvalid ? head[DATA_WIDTH] : 1'b0;
      assign out_pop       = m_axis_tvalid && m_axis_tready;
      assign st_pop        = out_pop;
    end else begin : g_oreg
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] out_data;
      logic                  out_last;
      logic                  load;

      assign out_pop       = out_valid && m_axis_tready;
      assign load          = (st_cnt != '0) && (!out_valid || out_pop);
      assign st_pop        = load;
      assign m_axis_tvalid = out_valid;
      assign m_axis_tdata  = out_data;
      assign m_axis_tlast  = out_last;

      // Output stage refills whenever it is empty or being drained; data holds otherwise
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_last  <= 1'b0;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (load) begin
          out_valid <= 1'b1;
          {out_last, out_data} <= mem[rd_ptr];
        end else if (out_pop) begin
          out_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sfifo_axis.sv
// tb/tb_sfifo_axis.sv - scoreboard bench for sfifo_axis, FWFT and output-register builds
module tb_sfifo_axis;

  localparam int DEPTH = 5;
  localparam int DW    = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          m_tready;

  logic [1:0]    s_tready;
  logic [DW-1:0] m_tdata [2];
  logic [1:0]    m_tlast;
  logic [1:0]    m_tvalid;
  logic [2:0]    level [2];
  logic [1:0]    af;
  logic [1:0]    ae;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sfifo_axis #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .OUT_REG(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready),
    .level(level[0]), .almost_full(af[0]), .almost_empty(ae[0])
  );

  sfifo_axis #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .OUT_REG(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready),
    .level(level[1]), .almost_full(af[1]), .almost_empty(ae[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
  endtask

  // Reference model: one queue of accepted {tlast,data} words per DUT
  logic [DW:0] q0 [$];
  logic [DW:0] q1 [$];
  int          cnt   [2];
  bit          stall [2];
  logic [DW:0] held  [2];

  // Monitor: samples mid-cycle, checks outputs against the model and advances it
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        chk("rst_tvalid", d, m_tvalid[d], 0);
        chk("rst_level", d, level[d], 0);
        chk("rst_tready", d, s_tready[d], 0);
        chk("rst_tdata", d, m_tdata[d], 0);
        cnt[d] = 0;
        stall[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
      end else if (flush) begin
        chk("flush_tready", d, s_tready[d], 0);
        cnt[d] = 0;
        stall[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        logic [DW:0] exp;
        int          qs;
        chk("level", d, level[d], cnt[d]);
        chk("almost_full", d, af[d], cnt[d] >= AF);
        chk("almost_empty", d, ae[d], cnt[d] <= AE);
        if (d == 0) begin
          chk("tvalid", d, m_tvalid[0], cnt[0] != 0);
          chk("tready", d, s_tready[0], cnt[0] < DEPTH);
        end else if (m_tvalid[1]) begin
          chk("tvalid_nonempty", d, cnt[1] != 0, 1);
        end
        if (stall[d]) begin
          chk("stall_tvalid", d, m_tvalid[d], 1);
          chk("stall_data", d, {m_tlast[d], m_tdata[d]}, held[d]);
        end
        if (m_tvalid[d] && m_tready) begin
          qs = (d == 0) ? q0.size() : q1.size();
          chk("queue_nonempty", d, qs != 0, 1);
          if (qs != 0) begin
            exp = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("out_word", d, {m_tlast[d], m_tdata[d]}, exp);
            cnt[d]--;
          end
        end
        if (s_tvalid && s_tready[d]) begin
          if (d == 0) q0.push_back({s_tlast, s_tdata}); else q1.push_back({s_tlast, s_tdata});
          cnt[d]++;
        end
        stall[d] = m_tvalid[d] && !m_tready;
        held[d]  = {m_tlast[d], m_tdata[d]};
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    s_tvalid = 0;
    m_tready = 1;
    repeat (n) cyc();
    m_tready = 0;
  endtask

  // Stimulus: directed scenarios followed by a randomized soak
  initial begin
    reset = 0; flush = 0; s_tdata = '0; s_tlast = 0; s_tvalid = 0; m_tready = 0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("init_tvalid", d, m_tvalid[d], 0);
      chk("init_level", d, level[d], 0);
      chk("init_tready", d, s_tready[d], 0);
      chk("init_ae", d, ae[d], 1);
      chk("init_af", d, af[d], 0);
    end
    cyc(); cyc();
    reset = 1;
    cyc();

    // Fill FWFT build to full with the reader stalled
    for (int i = 1; i <= 5; i++) begin
      s_tdata = DW'(i); s_tvalid = 1;
      cyc();
    end
    chk("full_level", 0, level[0], 5);
    chk("full_tready", 0, s_tready[0], 0);
    chk("full_af", 0, af[0], 1);
    s_tdata = 16'h0006;
    cyc(); cyc();
    chk("held_level", 0, level[0], 5);
    // Pop while full: the pending word must wait one more cycle
    m_tready = 1;
    cyc();
    m_tready = 0;
    chk("full_pop_level", 0, level[0], 4);
    chk("full_pop_tready", 0, s_tready[0], 1);
    cyc();
    chk("refill_level", 0, level[0], 5);
    drain(10);

    // Continuous streaming through several pointer wraps
    m_tready = 1;
    for (int i = 0; i < 20; i++) begin
      s_tdata = DW'(i); s_tvalid = 1;
      cyc();
      chk("stream_tvalid", 0, m_tvalid[0], 1);
      chk("stream_level", 0, level[0], 1);
    end
    drain(6);

    // Output-register latency and stability under backpressure
    s_tdata = 16'hBEEF; s_tlast = 1; s_tvalid = 1;
    cyc();
    s_tvalid = 0; s_tlast = 0;
    chk("beef_fwft_data", 0, m_tdata[0], 16'hBEEF);
    chk("beef_oreg_early", 1, m_tvalid[1], 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("beef_tvalid", 1, m_tvalid[1], 1);
      chk("beef_tdata", 1, m_tdata[1], 16'hBEEF);
      chk("beef_tlast", 1, m_tlast[1], 1);
      if (k < 3) cyc();
    end
    drain(4);

    // Flush with a concurrent write attempt
    for (int i = 0; i < 3; i++) begin
      s_tdata = DW'(16'h00A1 + i); s_tvalid = 1;
      cyc();
    end
    chk("preflush_level", 0, level[0], 3);
    flush = 1; s_tdata = 16'h0BAD;
    #1;
    chk("flush_cycle_tready", 0, s_tready[0], 0);
    cyc();
    flush = 0; s_tvalid = 0;
    for (int d = 0; d < 2; d++) begin
      chk("postflush_level", d, level[d], 0);
      chk("postflush_tvalid", d, m_tvalid[d], 0);
      chk("postflush_ae", d, ae[d], 1);
    end
    s_tdata = 16'h00AA; s_tvalid = 1;
    cyc();
    s_tvalid = 0;
    chk("after_flush_head", 0, m_tdata[0], 16'h00AA);
    drain(4);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 4; i++) begin
      s_tdata = DW'(16'h00B0 + i); s_tvalid = 1;
      cyc();
    end
    s_tvalid = 0;
    chk("prereset_level", 0, level[0], 4);
    @(posedge clk);
    #3;
    reset = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_tvalid", d, m_tvalid[d], 0);
      chk("async_level", d, level[d], 0);
      chk("async_tready", d, s_tready[d], 0);
    end
    cyc(); cyc();
    reset = 1;
    s_tdata = 16'h1234; s_tvalid = 1;
    cyc();
    s_tvalid = 0;
    chk("after_reset_head", 0, m_tdata[0], 16'h1234);
    chk("after_reset_tvalid", 0, m_tvalid[0], 1);
    drain(4);

    // Randomized soak with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      s_tvalid = ($urandom_range(0, 99) < 60);
      m_tready = ($urandom_range(0, 99) < 55);
      s_tdata  = DW'($urandom);
      s_tlast  = $urandom_range(0, 1) == 1;
      flush    = ($urandom_range(0, 99) == 0);
      cyc();
    end
    flush = 0;
    drain(12);
    chk("final_q0_empty", 0, q0.size(), 0);
    chk("final_q1_empty", 1, q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
